// File: rtl/branch_target_lut_if.sv
// Bundle of write, lookup, clear and response signals for branch_target_lut.
// Latency: none (wires only); the response side is registered inside the LUT.
// Backpressure: none; requests and writes are accepted every cycle.
interface branch_target_lut_if #(
   parameter int ADDR_W = 3,
   parameter int TGT_W  = 10,
   parameter int PC_W   = 10
);
   // table write port
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [TGT_W-1:0]  wr_data;

   // lookup request
   logic              req_valid;
   logic [ADDR_W-1:0] req_addr;
   logic              req_abs;
   logic [PC_W-1:0]   pc;

   // default-restore walk control
   logic              clear;

   // lookup response and status
   logic              resp_valid;
   logic [PC_W-1:0]   next_pc;
   logic [TGT_W-1:0]  resp_target;
   logic              busy;

   // fetch-side driver
   modport master (
      output wr_en, wr_addr, wr_data,
      output req_valid, req_addr, req_abs, pc,
      output clear,
      input  resp_valid, next_pc, resp_target, busy
   );

   // lookup table side
   modport slave (
      input  wr_en, wr_addr, wr_data,
      input  req_valid, req_addr, req_abs, pc,
      input  clear,
      output resp_valid, next_pc, resp_target, busy
   );
endinterface

// File: rtl/branch_target_lut.sv
// Branch-target table: pointer selects an offset/absolute target, next PC computed.
// Latency: 1 cycle from request sample to registered response.
// Backpressure: none; one request per cycle, writes dropped while clear walk runs.
module branch_target_lut #(
   parameter int ADDR_W = 3,
   parameter int TGT_W  = 10,
   parameter int PC_W   = 10
) (
   input logic                clk,
   input logic                reset,
   branch_target_lut_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [TGT_W-1:0]  lut_q [DEPTH];
   logic [TGT_W-1:0]  lut_d [DEPTH];

   logic              resp_valid_q, resp_valid_d;
   logic [PC_W-1:0]   next_pc_q, next_pc_d;
   logic [TGT_W-1:0]  resp_target_q, resp_target_d;

   logic              busy;
   logic              walk_we;
   logic              user_we;
   logic [TGT_W-1:0]  walk_data;
   logic [TGT_W-1:0]  lookup_entry;
   logic [PC_W-1:0]   lookup_pc;

   // Power-on / restore value of each entry, sign-extended or truncated to TGT_W.
   function automatic logic [TGT_W-1:0] dflt_entry(input logic [ADDR_W-1:0] idx);
      int v;
      if (idx == ADDR_W'(0)) begin
         v = -16;
      end else if (idx == ADDR_W'(1)) begin
         v = 3;
      end else if (idx == ADDR_W'(2)) begin
         v = 7;
      end else begin
         v = 1;
      end
      return TGT_W'(v);
   endfunction

   // FSM state and walk counter; reset aborts any walk in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: Clear only starts a walk from IDLE; walk ends after the last index.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.clear) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
            end
         end
         ST_CLEAR: begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST_IDX) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // FSM outputs: busy flag and which write source owns the table this cycle.
   always_comb begin
      busy      = (state_q == ST_CLEAR);
      walk_we   = busy;
      user_we   = bus.wr_en && !busy;
      walk_data = dflt_entry(cnt_q);
   end

   // Table next contents: walk restores one entry per cycle, otherwise user writes land.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         lut_d[i] = lut_q[i];
      end
      if (walk_we) begin
         lut_d[cnt_q] = walk_data;
      end else if (user_we) begin
         lut_d[bus.wr_addr] = bus.wr_data;
      end
   end

   // Table storage; reset reloads every entry with its default in one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            lut_q[i] <= dflt_entry(ADDR_W'(i));
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            lut_q[i] <= lut_d[i];
         end
      end
   end

   // Lookup with bypass of the value being written this same cycle, then PC math.
   always_comb begin
      lookup_entry = lut_q[bus.req_addr];
      if (walk_we && (bus.req_addr == cnt_q)) begin
         lookup_entry = walk_data;
      end else if (user_we && (bus.wr_addr == bus.req_addr)) begin
         lookup_entry = bus.wr_data;
      end
      if (bus.req_abs) begin
         // zero-extend or truncate the raw entry into PC space
         lookup_pc = PC_W'(lookup_entry);
      end else begin
         // entry is a signed offset; addition wraps modulo 2**PC_W
         lookup_pc = bus.pc + PC_W'($signed(lookup_entry));
      end
   end

   // Response next values: data is held whenever no request was sampled.
   always_comb begin
      resp_valid_d  = bus.req_valid;
      next_pc_d     = next_pc_q;
      resp_target_d = resp_target_q;
      if (bus.req_valid) begin
         next_pc_d     = lookup_pc;
         resp_target_d = lookup_entry;
      end
   end

   // Response registers; reset drops any request sampled in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         resp_valid_q  <= 1'b0;
         next_pc_q     <= '0;
         resp_target_q <= '0;
      end else begin
         resp_valid_q  <= resp_valid_d;
         next_pc_q     <= next_pc_d;
         resp_target_q <= resp_target_d;
      end
   end

   // Drive the interface outputs.
   always_comb begin
      bus.resp_valid  = resp_valid_q;
      bus.next_pc     = next_pc_q;
      bus.resp_target = resp_target_q;
      bus.busy        = busy;
   end
endmodule

// File: tb/tb_branch_target_lut.sv
// Directed bench for branch_target_lut with hand-computed expectations.
// Latency: checks each response one edge after its request.
// Backpressure: none exercised; requests issued back-to-back where needed.
module tb_branch_target_lut;
   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   branch_target_lut_if #(.ADDR_W(3), .TGT_W(10), .PC_W(10)) bus();

   branch_target_lut #(.ADDR_W(3), .TGT_W(10), .PC_W(10)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   logic [9:0] mdl [8];

   function automatic logic [9:0] dflt(input int i);
      case (i)
         0:       return 10'h3F0;
         1:       return 10'h003;
         2:       return 10'h007;
         default: return 10'h001;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.wr_en     = 1'b0;
      bus.wr_addr   = '0;
      bus.wr_data   = '0;
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.req_abs   = 1'b0;
      bus.pc        = '0;
      bus.clear     = 1'b0;
   endtask

   task automatic lookup(input string tag, input logic [2:0] a, input logic abs_m,
                         input logic [9:0] pc, input logic [9:0] exp_pc,
                         input logic [9:0] exp_tgt);
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      bus.req_abs   = abs_m;
      bus.pc        = pc;
      step();
      check({tag, "_vld"}, 32'(bus.resp_valid), 32'd1);
      check({tag, "_pc"},  32'(bus.next_pc), 32'(exp_pc));
      check({tag, "_tgt"}, 32'(bus.resp_target), 32'(exp_tgt));
      bus.req_valid = 1'b0;
   endtask

   task automatic write(input logic [2:0] a, input logic [9:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
      step();
      bus.wr_en = 1'b0;
      mdl[a]    = d;
   endtask

   task automatic read_all_defaults(input string tag);
      for (int i = 0; i < 8; i++) begin
         lookup($sformatf("%s%0d", tag, i), 3'(i), 1'b1, 10'h000, dflt(i), dflt(i));
      end
   endtask

   initial begin
      int n;
      logic [2:0] a;
      logic       m;
      logic [9:0] p;
      logic [9:0] e;

      reset = 1'b1;
      idle_inputs();
      for (int i = 0; i < 8; i++) mdl[i] = dflt(i);
      step();
      step();
      check("rst_vld", 32'(bus.resp_valid), 32'd0);
      check("rst_pc", 32'(bus.next_pc), 32'd0);
      check("rst_tgt", 32'(bus.resp_target), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      reset = 1'b0;

      // defaults, relative mode around PC 0x020
      lookup("def0", 3'd0, 1'b0, 10'h020, 10'h010, 10'h3F0);
      lookup("def1", 3'd1, 1'b0, 10'h020, 10'h023, 10'h003);
      lookup("def2", 3'd2, 1'b0, 10'h020, 10'h027, 10'h007);
      lookup("def5", 3'd5, 1'b0, 10'h020, 10'h021, 10'h001);

      // no request: valid drops, data held
      step();
      check("hold_vld", 32'(bus.resp_valid), 32'd0);
      check("hold_pc", 32'(bus.next_pc), 32'h021);
      check("hold_tgt", 32'(bus.resp_target), 32'h001);

      // wrap-around and absolute mode
      lookup("wrap_lo", 3'd0, 1'b0, 10'h005, 10'h3F5, 10'h3F0);
      lookup("wrap_hi", 3'd2, 1'b0, 10'h3FE, 10'h005, 10'h007);
      lookup("abs0", 3'd0, 1'b1, 10'h123, 10'h3F0, 10'h3F0);

      // same-cycle write bypass, then the stored value
      bus.wr_en   = 1'b1;
      bus.wr_addr = 3'd3;
      bus.wr_data = 10'h100;
      mdl[3]      = 10'h100;
      lookup("byp", 3'd3, 1'b0, 10'h010, 10'h110, 10'h100);
      bus.wr_en = 1'b0;
      lookup("byp_after", 3'd3, 1'b0, 10'h010, 10'h110, 10'h100);

      // clear walk over a fully reprogrammed table
      for (int i = 0; i < 8; i++) write(3'(i), 10'h055);
      bus.clear = 1'b1;
      step();
      bus.clear = 1'b0;
      n = 0;
      while (bus.busy && n < 20) begin
         // write into an already restored entry: must be dropped
         if (n == 1) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = 3'd0;
            bus.wr_data = 10'h2AA;
         end
         // lookup of the entry restored this cycle sees its default
         if (n == 2) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = 3'd2;
            bus.req_abs   = 1'b0;
            bus.pc        = 10'h000;
         end
         step();
         if (n == 2) check("walk_byp_tgt", 32'(bus.resp_target), 32'h007);
         bus.wr_en     = 1'b0;
         bus.req_valid = 1'b0;
         n++;
      end
      check("walk_len", 32'(n), 32'd8);
      for (int i = 0; i < 8; i++) mdl[i] = dflt(i);
      read_all_defaults("clr");

      // reset in the third busy cycle aborts the walk and restores everything
      write(3'd1, 10'h0AA);
      write(3'd4, 10'h0BB);
      write(3'd7, 10'h0CC);
      bus.clear = 1'b1;
      step();
      bus.clear = 1'b0;
      check("mid_busy1", 32'(bus.busy), 32'd1);
      step();
      step();
      check("mid_busy3", 32'(bus.busy), 32'd1);
      reset         = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_addr  = 3'd4;
      step();
      reset         = 1'b0;
      bus.req_valid = 1'b0;
      check("mid_busy", 32'(bus.busy), 32'd0);
      check("mid_vld", 32'(bus.resp_valid), 32'd0);
      check("mid_pc", 32'(bus.next_pc), 32'd0);
      for (int i = 0; i < 8; i++) mdl[i] = dflt(i);
      read_all_defaults("mrst");

      // back-to-back random requests against the reference model
      write(3'd5, 10'h200);
      write(3'd6, 10'h1FF);
      for (int k = 0; k < 8; k++) begin
         a = 3'($urandom_range(0, 7));
         m = 1'($urandom_range(0, 1));
         p = 10'($urandom_range(0, 1023));
         e = m ? mdl[a] : 10'(p + mdl[a]);
         bus.req_valid = 1'b1;
         bus.req_addr  = a;
         bus.req_abs   = m;
         bus.pc        = p;
         step();
         check($sformatf("b2b%0d_vld", k), 32'(bus.resp_valid), 32'd1);
         check($sformatf("b2b%0d_pc", k), 32'(bus.next_pc), 32'(e));
         check($sformatf("b2b%0d_tgt", k), 32'(bus.resp_target), 32'(mdl[a]));
      end
      bus.req_valid = 1'b0;
      step();
      check("b2b_end_vld", 32'(bus.resp_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/branch_target_lut.md
# branch_target_lut

Programmable, parametrised branch-target lookup table for the fetch stage. A narrow branch-field pointer selects a wide offset or absolute target. The block computes the next PC from it with a one-cycle registered latency. Entries reset to the fixed default table (−16, +3, +7, then +1). They are rewritable at run time through a write port and can be restored by a sequential clear walk.

## Interface
- ADDR_W, 3, pointer width; DEPTH = 2**ADDR_W entries
- TGT_W, 10, entry width (two's-complement offset or absolute target)
- PC_W, 10, program-counter width
- Clk  input  1  clock, all state on rising edge
- Reset  input  1  synchronous, active-high
- WrEn  input  1  write entry WrAddr with WrData this cycle
- WrAddr  input  ADDR_W  write pointer
- WrData  input  TGT_W  write value
- ReqValid  input  1  lookup request this cycle
- ReqAddr  input  ADDR_W  lookup pointer
- ReqAbs  input  1  1 = absolute mode, 0 = PC-relative mode
- PC  input  PC_W  current PC of the branch
- Clear  input  1  pulse: start default-restore walk
- RespValid  output  1  NextPC/RespTarget valid
- NextPC  output  PC_W  computed next PC
- RespTarget  output  TGT_W  raw entry value used
- Busy  output  1  clear walk in progress

## Operation
- Default table D[i]: D[0] = −16, D[1] = +3, D[2] = +7, D[i≥3] = +1. Each value is sign-extended or truncated to TGT_W.
- Relative mode: NextPC = (PC + sext(entry to PC_W)) mod 2^PC_W. Wrap-around is silent.
- Absolute mode: NextPC = entry zero-extended to PC_W, or truncated to the low PC_W bits if TGT_W > PC_W.
- Write: when WrEn=1 and Busy=0, table[WrAddr] ← WrData at the clock edge.
- Write bypass: if WrEn, ReqValid and WrAddr==ReqAddr occur in the same cycle with Busy=0, the lookup uses WrData, not the old entry.
- FSM, two states:
  - IDLE: Busy=0. Clear=1 → CLEAR, walk counter ← 0.
  - CLEAR: Busy=1. Each cycle, table[cnt] ← D[cnt] and cnt increments. After writing cnt = DEPTH−1, the FSM returns to IDLE.
  - The walk takes exactly DEPTH cycles.
- During CLEAR:
  - WrEn is ignored and dropped.
  - Clear is ignored.
  - Lookups are still served from current contents. An entry being restored in the same cycle as its lookup returns D[cnt] (bypass).
- Reset: all entries ← D in one cycle; FSM → IDLE, cnt ← 0. Reset mid-walk aborts the walk.
- Reset priority over Clear, WrEn and ReqValid in the same cycle. The request is dropped.

## Timing
- Lookup latency is 1 cycle. A request at edge n gives RespValid=1 and the data after edge n+1, held for one cycle.
- Fully pipelined, one request per cycle, no backpressure.
- RespValid=0 after a cycle with ReqValid=0. NextPC and RespTarget hold their last values when RespValid=0.
- Reset values: RespValid=0, NextPC=0, RespTarget=0, Busy=0.
- A write at edge n is visible to requests sampled at edge n (via bypass) and at every later edge.
- Clear sampled at edge n gives Busy=1 from n+1 through n+DEPTH, then Busy=0.

## Test plan
- Reset then defaults: with PC=10'h020 and relative mode, request addr 0,1,2,5 → NextPC = 0x010, 0x023, 0x027, 0x021. RespTarget = 0x3F0, 0x003, 0x007, 0x001. Each response arrives 1 cycle after its request.
- Wrap and absolute mode:
  - Relative: PC=0x005, addr 0 → NextPC=0x3F5.
  - Relative: PC=0x3FE, addr 2 → NextPC=0x005.
  - Absolute: addr 0 → NextPC=0x3F0.
- Write and bypass: write addr 3 ← 0x100 while requesting addr 3, relative, PC=0x010 → NextPC=0x110. The next cycle, request addr 3 → still 0x110.
- Clear walk: program all entries to 0x055, pulse Clear → Busy high exactly 8 cycles. A WrEn during the walk has no effect. Afterwards, every entry reads D[i].
- Reset mid-walk: assert Reset on the 3rd Busy cycle with ReqValid=1 → next cycle Busy=0, RespValid=0, all entries = D.
- Back-to-back: 8 consecutive requests with random pointers and modes → 8 consecutive responses, each matching the reference model in order.
